// File: rtl/serial_cmd_detect.sv
// serial_cmd_detect: deserialises framed L1/R3 commands from a single-bit
// stream, queues decoded {type, id} entries in a small output FIFO with a
// valid/ready handshake, and keeps per-type counters plus error/overflow status.
module serial_cmd_detect #(
   parameter int                   HDR_WIDTH  = 3,
   parameter logic [HDR_WIDTH-1:0] HDR_L1     = 3'b110,
   parameter logic [HDR_WIDTH-1:0] HDR_R3     = 3'b101,
   parameter int                   ID_WIDTH   = 8,
   parameter int                   FIFO_DEPTH = 4,
   parameter int                   CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          Reset,
   input  logic                          L1DataIn,
   input  logic                          clr_i,
   output logic                          cmd_valid_o,
   input  logic                          cmd_ready_i,
   output logic                          cmd_type_o,
   output logic [ID_WIDTH-1:0]           cmd_id_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          hdr_err_o,
   output logic                          overflow_o,
   output logic [CNT_WIDTH-1:0]          l1_count_o,
   output logic [CNT_WIDTH-1:0]          r3_count_o
);

   localparam int SR_W = (HDR_WIDTH > ID_WIDTH) ? HDR_WIDTH : ID_WIDTH;
   localparam int BCW  = $clog2(SR_W) + 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int FCW  = AW + 1;
   localparam int EW   = ID_WIDTH + 1;
   localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_LAST    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [BCW-1:0]        cnt_q, cnt_d;
   logic [SR_W-1:0]       sr_q, sr_d;
   logic                  typ_q, typ_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [EW-1:0]         mem_d [FIFO_DEPTH];
   logic [AW-1:0]         wr_q, wr_d;
   logic [AW-1:0]         rd_q, rd_d;
   logic [FCW-1:0]        count_q, count_d;
   logic                  valid_q, valid_d;
   logic [EW-1:0]         head_q, head_d;
   logic                  err_q, err_d;
   logic                  ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0]  l1_q, l1_d;
   logic [CNT_WIDTH-1:0]  r3_q, r3_d;

   logic [BCW-1:0]        idx_s;
   logic [HDR_WIDTH-1:0]  hdr_now_s;
   logic [ID_WIDTH-1:0]   id_now_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  accept_s;
   logic                  drop_s;
   logic [EW-1:0]         entry_s;

   // Field capture: each header/ID bit lands at its MSB-first position, so the
   // field including the current bit is directly readable from sr_d.
   always_comb begin
      sr_d = sr_q;
      if (state_q == S_HEADER) begin
         idx_s = BCW'(HDR_WIDTH - 1) - cnt_q;
      end else if (state_q == S_PAYLOAD) begin
         idx_s = BCW'(ID_WIDTH - 1) - cnt_q;
      end else begin
         idx_s = {BCW{1'b0}};
      end
      for (int k = 0; k < SR_W; k++) begin
         if (((state_q == S_HEADER) || (state_q == S_PAYLOAD)) && (BCW'(k) == idx_s)) begin
            sr_d[k] = L1DataIn;
         end else begin
            sr_d[k] = sr_q[k];
         end
      end
   end

   assign hdr_now_s = sr_d[HDR_WIDTH-1:0];
   assign id_now_s  = sr_d[ID_WIDTH-1:0];
   assign entry_s   = {typ_q, id_now_s};

   // Frame FSM next state: start bit, header match (L1 has priority), payload count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      typ_d   = typ_q;
      err_d   = 1'b0;
      push_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (L1DataIn) begin
               state_d = S_HEADER;
               cnt_d   = {BCW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HEADER: begin
            if (cnt_q == BCW'(HDR_WIDTH - 1)) begin
               cnt_d = {BCW{1'b0}};
               if (hdr_now_s == HDR_L1) begin
                  state_d = S_PAYLOAD;
                  typ_d   = 1'b0;
               end else if (hdr_now_s == HDR_R3) begin
                  state_d = S_PAYLOAD;
                  typ_d   = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + BCW'(1);
            end
         end
         S_PAYLOAD: begin
            if (cnt_q == BCW'(ID_WIDTH - 1)) begin
               cnt_d   = {BCW{1'b0}};
               push_s  = 1'b1;
               state_d = S_LAST;
            end else begin
               cnt_d = cnt_q + BCW'(1);
            end
         end
         S_LAST: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output FIFO: a full FIFO still accepts a push when the head pops in the
   // same cycle; the head register is loaded from the post-update contents.
   always_comb begin
      mem_d    = mem_q;
      pop_s    = valid_q & cmd_ready_i;
      accept_s = push_s & ((count_q < DEPTH_C) | pop_s);
      drop_s   = push_s & ~accept_s;
      if (accept_s) begin
         mem_d[wr_q] = entry_s;
         wr_d        = wr_q + AW'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + AW'(1);
      end else begin
         rd_d = rd_q;
      end
      count_d = count_q + FCW'(accept_s) - FCW'(pop_s);
      valid_d = (count_d != {FCW{1'b0}});
      if (valid_d) begin
         head_d = mem_d[rd_d];
      end else begin
         head_d = head_q;
      end
   end

   // Per-type counters and sticky overflow; a clear overrides a same-cycle update.
   always_comb begin
      if (clr_i) begin
         l1_d  = {CNT_WIDTH{1'b0}};
         r3_d  = {CNT_WIDTH{1'b0}};
         ovf_d = 1'b0;
      end else begin
         l1_d  = l1_q + CNT_WIDTH'(accept_s & ~typ_q);
         r3_d  = r3_q + CNT_WIDTH'(accept_s & typ_q);
         ovf_d = ovf_q | drop_s;
      end
   end

   // State, FIFO control and status registers.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= {BCW{1'b0}};
         sr_q    <= {SR_W{1'b0}};
         typ_q   <= 1'b0;
         wr_q    <= {AW{1'b0}};
         rd_q    <= {AW{1'b0}};
         count_q <= {FCW{1'b0}};
         valid_q <= 1'b0;
         head_q  <= {EW{1'b0}};
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         l1_q    <= {CNT_WIDTH{1'b0}};
         r3_q    <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         typ_q   <= typ_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         l1_q    <= l1_d;
         r3_q    <= r3_d;
      end
   end

   // FIFO storage; only slots between the pointers are ever read, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign cmd_valid_o  = valid_q;
   assign cmd_type_o   = head_q[EW-1];
   assign cmd_id_o     = head_q[ID_WIDTH-1:0];
   assign fifo_count_o = count_q;
   assign hdr_err_o    = err_q;
   assign overflow_o   = ovf_q;
   assign l1_count_o   = l1_q;
   assign r3_count_o   = r3_q;

endmodule

// File: tb/tb_serial_cmd_detect.sv
// Scoreboard bench for serial_cmd_detect: frames are built as annotated bit
// lists, a queue-based reference model predicts FIFO contents and status, and
// a negedge monitor compares DUT outputs and popped entries.
module tb_serial_cmd_detect;

   localparam int H  = 3;
   localparam int I  = 8;
   localparam int D  = 4;
   localparam int CW = 4;
   localparam logic [2:0] P_L1 = 3'b110;
   localparam logic [2:0] P_R3 = 3'b101;

   logic          clk;
   logic          Reset;
   logic          L1DataIn;
   logic          clr_i;
   logic          cmd_valid_o;
   logic          cmd_ready_i;
   logic          cmd_type_o;
   logic [I-1:0]  cmd_id_o;
   logic [2:0]    fifo_count_o;
   logic          hdr_err_o;
   logic          overflow_o;
   logic [CW-1:0] l1_count_o;
   logic [CW-1:0] r3_count_o;

   serial_cmd_detect #(
      .HDR_WIDTH(H), .HDR_L1(P_L1), .HDR_R3(P_R3),
      .ID_WIDTH(I), .FIFO_DEPTH(D), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .Reset(Reset), .L1DataIn(L1DataIn), .clr_i(clr_i),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_type_o(cmd_type_o), .cmd_id_o(cmd_id_o),
      .fifo_count_o(fifo_count_o), .hdr_err_o(hdr_err_o),
      .overflow_o(overflow_o), .l1_count_o(l1_count_o), .r3_count_o(r3_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tag: 0 plain bit, 1 last ID bit of a command, 2 last bit of a bad header
   typedef struct {
      logic       b;
      int         tag;
      logic       t;
      logic [7:0] id;
      logic       rst;
      logic       clr;
   } ent_t;

   ent_t       bq[$];
   logic [8:0] exp_q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         mode = 1;
   int         m_cnt = 0;
   int         m_l1 = 0;
   int         m_r3 = 0;
   logic       m_ovf = 1'b0;
   logic       m_err = 1'b0;
   logic       m_rst_vals = 1'b0;
   bit         started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic ent_t mk(input logic b);
      ent_t e;
      e.b = b; e.tag = 0; e.t = 1'b0; e.id = 8'h00; e.rst = 1'b0; e.clr = 1'b0;
      return e;
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) bq.push_back(mk(1'b0));
   endtask

   task automatic reset_cycles(input int n);
      ent_t e;
      for (int k = 0; k < n; k++) begin
         e = mk(1'b0); e.rst = 1'b1; bq.push_back(e);
      end
   endtask

   task automatic send_cmd(input logic t, input logic [7:0] id, input logic last_bit, input logic clr_last);
      ent_t e;
      logic [2:0] h;
      h = t ? P_R3 : P_L1;
      bq.push_back(mk(1'b1));
      for (int k = H - 1; k >= 0; k--) bq.push_back(mk(h[k]));
      for (int k = I - 1; k >= 0; k--) begin
         e = mk(id[k]);
         if (k == 0) begin
            e.tag = 1; e.t = t; e.id = id; e.clr = clr_last;
         end
         bq.push_back(e);
      end
      bq.push_back(mk(last_bit));
   endtask

   task automatic send_bad(input logic [2:0] h);
      ent_t e;
      bq.push_back(mk(1'b1));
      for (int k = H - 1; k >= 0; k--) begin
         e = mk(h[k]);
         if (k == 0) e.tag = 2;
         bq.push_back(e);
      end
   endtask

   // start + header + three ID bits (edges 0..6), Reset sampled at edge 7
   task automatic send_reset_mid(input logic [7:0] id);
      ent_t e;
      bq.push_back(mk(1'b1));
      for (int k = H - 1; k >= 0; k--) bq.push_back(mk(P_L1[k]));
      for (int k = I - 1; k >= I - 3; k--) bq.push_back(mk(id[k]));
      e = mk(1'b1); e.rst = 1'b1; bq.push_back(e);
   endtask

   // Reference model: effect of one clock edge given the inputs applied to it.
   task automatic model_step(input ent_t e, input logic rdy);
      logic pop, acc;
      if (e.rst) begin
         m_cnt = 0; exp_q.delete(); m_l1 = 0; m_r3 = 0;
         m_ovf = 1'b0; m_err = 1'b0; m_rst_vals = 1'b1;
      end else begin
         pop = rdy && (m_cnt > 0);
         acc = (e.tag == 1) && ((m_cnt < D) || pop);
         if (acc) begin
            exp_q.push_back({e.t, e.id});
            m_rst_vals = 1'b0;
            if (e.t) m_r3 = (m_r3 + 1) % (1 << CW);
            else     m_l1 = (m_l1 + 1) % (1 << CW);
         end
         if ((e.tag == 1) && !acc) m_ovf = 1'b1;
         m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
         if (e.clr) begin
            m_l1 = 0; m_r3 = 0; m_ovf = 1'b0;
         end
         m_err = (e.tag == 2);
      end
   endtask

   task automatic drive_cycle(input ent_t e);
      logic r;
      case (mode)
         0:       r = 1'b0;
         1:       r = 1'b1;
         2:       r = 1'($urandom % 2);
         3:       r = (e.tag == 1);
         default: r = (($urandom % 8) == 0);
      endcase
      L1DataIn    = e.b;
      Reset       = e.rst;
      clr_i       = e.clr;
      cmd_ready_i = r;
      @(posedge clk);
      #1;
      model_step(e, r);
      started = 1'b1;
   endtask

   task automatic run();
      ent_t e;
      while (bq.size() > 0) begin
         e = bq.pop_front();
         drive_cycle(e);
      end
   endtask

   // Monitor: status against the model every cycle, head against the
   // scoreboard whenever the DUT is about to hand an entry over.
   always @(negedge clk) begin
      logic [8:0] x;
      if (started) begin
         chk("fifo_count", 32'(fifo_count_o), m_cnt);
         chk("cmd_valid", 32'(cmd_valid_o), 32'(m_cnt > 0));
         chk("hdr_err", 32'(hdr_err_o), 32'(m_err));
         chk("overflow", 32'(overflow_o), 32'(m_ovf));
         chk("l1_count", 32'(l1_count_o), m_l1);
         chk("r3_count", 32'(r3_count_o), m_r3);
         if (m_rst_vals) begin
            chk("reset_type", 32'(cmd_type_o), 32'd0);
            chk("reset_id", 32'(cmd_id_o), 32'd0);
         end
         if (cmd_valid_o && cmd_ready_i && !Reset) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL pop_empty: got pop of %0h expected no entry at t=%0t", cmd_id_o, $time);
            end else begin
               x = exp_q.pop_front();
               chk("pop_type", 32'(cmd_type_o), 32'(x[8]));
               chk("pop_id", 32'(cmd_id_o), 32'(x[7:0]));
            end
         end
      end
   end

   initial begin
      logic [2:0] bh;
      ent_t       e;
      Reset = 1'b1; L1DataIn = 1'b0; clr_i = 1'b0; cmd_ready_i = 1'b0;

      mode = 1; reset_cycles(2); idle(2); run();

      // L1 0xA5 (ignored '1' in LAST), then back-to-back R3 0x3C / L1 0x0F
      mode = 0;
      send_cmd(1'b0, 8'hA5, 1'b1, 1'b0); idle(3);
      send_cmd(1'b1, 8'h3C, 1'b0, 1'b0); send_cmd(1'b0, 8'h0F, 1'b1, 1'b0);
      run();
      mode = 1; idle(6); run();

      // Bad header followed immediately by a valid start bit
      send_bad(3'b011); send_cmd(1'b1, 8'h5A, 1'b0, 1'b0); idle(2); run();

      // Overflow, then a push that coincides with a pop while full
      mode = 0;
      for (int k = 0; k < 5; k++) send_cmd(1'b0, 8'(8'h20 + k), 1'b0, 1'b0);
      run();
      mode = 3; send_cmd(1'b0, 8'h66, 1'b0, 1'b0); run();

      // Reset mid-payload, then a clean frame
      mode = 0; idle(2); send_reset_mid(8'h99); idle(1);
      send_cmd(1'b0, 8'h42, 1'b0, 1'b0); run();

      // Clear coinciding with an increment
      mode = 1; idle(4); send_cmd(1'b1, 8'h11, 1'b0, 1'b1); idle(2); run();

      // Counter wrap: 17 L1 commands after a clear
      e = mk(1'b0); e.clr = 1'b1; bq.push_back(e);
      for (int k = 0; k < 17; k++) send_cmd(1'b0, 8'($urandom), 1'($urandom % 2), 1'b0);
      run();

      // Randomised traffic with random and sparse ready
      for (int ph = 0; ph < 2; ph++) begin
         mode = (ph == 0) ? 2 : 4;
         for (int k = 0; k < 22; k++) begin
            if (($urandom % 8) == 0) begin
               bh = 3'($urandom);
               while ((bh == P_L1) || (bh == P_R3)) bh = 3'($urandom);
               send_bad(bh);
            end else begin
               send_cmd(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1'b0);
            end
            for (int g = 0; g < int'($urandom % 3); g++) begin
               e = mk(1'b0);
               e.clr = (($urandom % 10) == 0);
               bq.push_back(e);
            end
         end
         run();
      end

      mode = 1; idle(10); run();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
